vram_writer: RTL and testbench

- CPU-side VRAM write path for SE-VGA; the counterpart of the video fetch path, which only reads VRAM.
- Snoops 68000 word writes that land in the SE main-screen framebuffer and queues them in a small FIFO.
- Splits each word into byte writes on the 8-bit VRAM.
- Issues each byte write only in pixel-clock slots that cannot collide with the video fetch, which asserts nvramOE at hCount[2:0]==7.

---
 rtl/sevga_pkg.sv | 25 ++
 rtl/vram_writer_if.sv | 32 +++
 rtl/vram_wr_fifo.sv | 62 ++++++
 rtl/vram_writer.sv | 104 ++++++++++
 tb/tb_vram_writer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sevga_pkg.sv
// SE-VGA shared types and defaults for the CPU-side VRAM write path.
// Holds framebuffer window defaults, the queued write entry and the writer FSM states.
// Also provides the slot rule that decides when a VRAM write may start.
package sevga_pkg;

    // SE main screen buffer in the 4MB configuration: 342 lines x 64 bytes.
    localparam logic [23:0] SEVGA_FB_BASE  = 24'h3FA700;
    localparam int unsigned SEVGA_FB_BYTES = 21888;

    typedef struct packed {
        logic [13:0] wordOff;
        logic [15:0] data;
        logic        ube;
        logic        lbe;
    } wr_entry_t;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wr_state_t;

    // The video fetch owns the VRAM at phase 7. A write takes SETUP/STROBE/HOLD,
    // so SETUP must land in phase 0..4, i.e. the deciding cycle is in {7,0,1,2,3}.
    function automatic logic phase_ok(input logic [2:0] ph);
        return (ph == 3'd7) || (ph <= 3'd3);
    endfunction

endpackage

// File: rtl/vram_writer_if.sv
// Bundle between the CPU snoop / timing side and the VRAM writer.
// master: CPU strobe, address, data, byte strobes and hPhase out; VRAM bus and status in.
// slave: the writer; drives vramAddr/vramDout/nvramWE/vramDrive/overflow/fifoCount.
interface vram_writer_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          cpuWrStb;
    logic [22:0]   cpuAddr;
    logic [15:0]   cpuData;
    logic          nUDS;
    logic          nLDS;
    logic [2:0]    hPhase;
    logic [14:0]   vramAddr;
    logic [7:0]    vramDout;
    logic          nvramWE;
    logic          vramDrive;
    logic          overflow;
    logic [CW-1:0] fifoCount;

    modport master (
        output cpuWrStb, cpuAddr, cpuData, nUDS, nLDS, hPhase,
        input  vramAddr, vramDout, nvramWE, vramDrive, overflow, fifoCount
    );

    modport slave (
        input  cpuWrStb, cpuAddr, cpuData, nUDS, nLDS, hPhase,
        output vramAddr, vramDout, nvramWE, vramDrive, overflow, fifoCount
    );

endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO of wr_entry_t; head visible on rdata_o while not empty.
// Latency: a push is visible at the head the cycle after its edge.
// Backpressure: push while full is ignored unless a pop in the same cycle frees the slot.
// Ports: clk_i/rst_i, push_i/wdata_i, pop_i/rdata_o, full_o, empty_o, count_o.
module vram_wr_fifo
    import sevga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  wr_entry_t                wdata_i,
    input  logic                     pop_i,
    output wr_entry_t                rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wr_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/vram_writer.sv
// CPU-side VRAM write path: snoops framebuffer word writes, queues them, and
// writes them byte-by-byte into 8-bit VRAM outside the phase-7 video fetch slot.
// Latency: SETUP one cycle after the push edge at best; 3 cycles per byte.
// Backpressure: none toward the CPU; a write arriving with the queue full is dropped and flags overflow.
// Ports: pixClock, reset (sync, active high), bus (slave side of vram_writer_if).
module vram_writer
    import sevga_pkg::*;
#(
    parameter logic [23:0] FB_BASE    = SEVGA_FB_BASE,
    parameter int unsigned FB_BYTES   = SEVGA_FB_BYTES,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic          pixClock,
    input  logic          reset,
    vram_writer_if.slave  bus
);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [23:0] FB_END    = FB_BASE + 24'(FB_BYTES);
    // FB_BASE is even, so the word offset is just the low word-address bits minus the base word.
    localparam logic [13:0] BASE_WORD = FB_BASE[14:1];

    wr_state_t     state_q, state_d;
    logic          upper_done_q, upper_done_d;
    logic          overflow_q, overflow_d;

    logic [23:0]   byte_addr;
    logic          in_win, qualify;
    wr_entry_t     push_entry, head;
    logic          fifo_full, fifo_empty, pop;
    logic [CW-1:0] fifo_count;
    logic          cur_lower, last_byte, more_work, drive;

    // Full 24-bit compares, so addresses below the base cannot wrap into the window.
    assign byte_addr = {bus.cpuAddr, 1'b0};
    assign in_win    = (byte_addr >= FB_BASE) && (byte_addr < FB_END);
    assign qualify   = bus.cpuWrStb && in_win && !(bus.nUDS && bus.nLDS);

    always_comb begin
        push_entry.wordOff = bus.cpuAddr[13:0] - BASE_WORD;
        push_entry.data    = bus.cpuData;
        push_entry.ube     = ~bus.nUDS;
        push_entry.lbe     = ~bus.nLDS;
    end

    vram_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (pixClock),
        .rst_i   (reset),
        .push_i  (qualify),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Byte in flight: upper first when enabled, lower once the upper is done.
    assign cur_lower = upper_done_q || !head.ube;
    assign last_byte = cur_lower || !head.lbe;
    assign pop       = (state_q == HOLD) && last_byte;
    // Work remains after this HOLD if the entry has another byte, another entry
    // is queued, or a write is being pushed right now (always accepted when popping).
    assign more_work = !last_byte || (fifo_count > CW'(1)) || qualify;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty && phase_ok(bus.hPhase)) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  state_d = HOLD;
            HOLD:    state_d = (more_work && phase_ok(bus.hPhase)) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        upper_done_d = upper_done_q;
        if (pop)                    upper_done_d = 1'b0;
        else if (state_q == HOLD)   upper_done_d = 1'b1;
        overflow_d = overflow_q || (qualify && fifo_full && !pop);
    end

    always_ff @(posedge pixClock) begin
        if (reset) begin
            state_q      <= IDLE;
            upper_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            upper_done_q <= upper_done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Head entry is stable from SETUP through HOLD: it only advances on the pop edge.
    assign drive         = (state_q != IDLE);
    assign bus.vramDrive = drive;
    assign bus.nvramWE   = (state_q != STROBE);
    assign bus.vramAddr  = drive ? {head.wordOff, cur_lower} : '0;
    assign bus.vramDout  = !drive ? '0 : (cur_lower ? head.data[7:0] : head.data[15:8]);
    assign bus.overflow  = overflow_q;
    assign bus.fifoCount = fifo_count;

endmodule

// File: tb/tb_vram_writer.sv
// Directed and random bench for vram_writer with a scoreboard of expected VRAM byte writes.
module tb_vram_writer;
    import sevga_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [23:0] BASE  = 24'h3FA700;
    localparam logic [23:0] FBEND = 24'h3FFC80;

    logic        clk = 1'b0;
    logic        reset;
    logic        prev_we;
    int          checks = 0;
    int          errors = 0;
    int          writes = 0;
    int          wb;
    logic [22:0] exp_q[$];
    logic [23:0] a;
    logic [15:0] d;
    logic        nu, nl;
    int          sel;

    vram_writer_if #(.FIFO_DEPTH(DEPTH)) bus();

    vram_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .pixClock (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: window test and byte split, upper byte first.
    task automatic expect_word(input logic [23:0] ad, input logic [15:0] dd,
                               input logic u, input logic l);
        logic [23:0] off;
        off = ad - BASE;
        if (ad >= BASE && ad < FBEND) begin
            if (!u) exp_q.push_back({off[14:1], 1'b0, dd[15:8]});
            if (!l) exp_q.push_back({off[14:1], 1'b1, dd[7:0]});
        end
    endtask

    // Called at posedge+2; one-cycle strobe; returns at the next posedge+2.
    task automatic cpu_wr(input logic [23:0] ad, input logic [15:0] dd,
                          input logic u, input logic l, input logic accept);
        if (accept) expect_word(ad, dd, u, l);
        bus.cpuWrStb = 1'b1;
        bus.cpuAddr  = ad[23:1];
        bus.cpuData  = dd;
        bus.nUDS     = u;
        bus.nLDS     = l;
        @(posedge clk); #2;
        bus.cpuWrStb = 1'b0;
        bus.nUDS     = 1'b1;
        bus.nLDS     = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 400 && !(exp_q.size() == 0 && bus.fifoCount == 0 && bus.vramDrive == 1'b0); i++) begin
            @(posedge clk); #2;
        end
        repeat (10) begin @(posedge clk); #2; end
        chk(tag, exp_q.size(), 0);
        chk({tag, "_count"}, 32'(bus.fifoCount), 0);
    endtask

    initial begin
        reset        = 1'b1;
        bus.cpuWrStb = 1'b0;
        bus.cpuAddr  = '0;
        bus.cpuData  = '0;
        bus.nUDS     = 1'b1;
        bus.nLDS     = 1'b1;
        bus.hPhase   = 3'd0;
        prev_we      = 1'b1;

        fork
            forever begin
                @(posedge clk); #1;
                bus.hPhase = bus.hPhase + 3'd1;
            end
            forever begin
                @(negedge clk);
                if (bus.nvramWE === 1'b0) begin
                    logic [22:0] e;
                    writes++;
                    chk("we_phase_le5", 32'(bus.hPhase <= 3'd5), 1);
                    chk("we_single_cycle", 32'(prev_we), 1);
                    chk("write_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("write_addr_data", {9'b0, bus.vramAddr, bus.vramDout}, {9'b0, e});
                    end
                end
                prev_we = bus.nvramWE;
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_addr", 32'(bus.vramAddr), 0);
        chk("rst_dout", 32'(bus.vramDout), 0);
        chk("rst_we", 32'(bus.nvramWE), 1);
        chk("rst_drive", 32'(bus.vramDrive), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_count", 32'(bus.fifoCount), 0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Word write, both strobes
        cpu_wr(24'h3FA700, 16'hA55A, 1'b0, 1'b0, 1'b1);
        chk("word_pushed", 32'(bus.fifoCount), 1);
        drain("word_drain");

        // Lower strobe only
        wb = writes;
        cpu_wr(24'h3FA740, 16'h12FF, 1'b1, 1'b0, 1'b1);
        drain("lds_drain");
        chk("lds_one_write", writes - wb, 1);

        // Out-of-window writes and a write with no byte strobe
        wb = writes;
        cpu_wr(24'h3FA6FE, 16'h1111, 1'b0, 1'b0, 1'b1);
        chk("below_base_ignored", 32'(bus.fifoCount), 0);
        cpu_wr(24'h3FFC80, 16'h2222, 1'b0, 1'b0, 1'b1);
        chk("past_end_ignored", 32'(bus.fifoCount), 0);
        cpu_wr(24'h000000, 16'h3333, 1'b0, 1'b0, 1'b1);
        chk("zero_ignored", 32'(bus.fifoCount), 0);
        cpu_wr(24'h3FA800, 16'h4444, 1'b1, 1'b1, 1'b1);
        chk("no_strobe_ignored", 32'(bus.fifoCount), 0);
        drain("ignored_drain");
        chk("ignored_no_writes", writes - wb, 0);

        // Six back-to-back strobes: four fit, two dropped
        wb = writes;
        for (int k = 0; k < 6; k++)
            cpu_wr(BASE + 24'(k * 4), 16'(16'h0102 + k * 16'h1111), 1'b0, 1'b0, k < 4);
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_full_count", 32'(bus.fifoCount), DEPTH);
        drain("ovf_drain");
        chk("ovf_eight_writes", writes - wb, 8);
        chk("ovf_sticky", 32'(bus.overflow), 1);

        // Push in phase 4: SETUP waits for phase 0
        for (int i = 0; i < 16 && bus.hPhase != 3'd4; i++) begin @(posedge clk); #2; end
        chk("at_phase4", 32'(bus.hPhase), 4);
        cpu_wr(BASE + 24'h100, 16'h3C3C, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 16 && bus.vramDrive !== 1'b1; i++) @(negedge clk);
        chk("setup_seen", 32'(bus.vramDrive), 1);
        chk("setup_phase0", 32'(bus.hPhase), 0);
        @(posedge clk); #2;
        drain("phase_drain");

        // Random writes with random gaps
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(0, 5)) begin @(posedge clk); #2; end
            for (int w = 0; w < 200 && bus.fifoCount == DEPTH; w++) begin @(posedge clk); #2; end
            sel = int'($urandom_range(0, 15));
            if (sel == 0)      a = BASE - 24'(2 + 2 * $urandom_range(0, 1000));
            else if (sel == 1) a = FBEND + 24'(2 * $urandom_range(0, 1000));
            else               a = BASE + 24'(2 * $urandom_range(0, 10943));
            d  = 16'($urandom);
            nu = 1'($urandom_range(0, 1));
            nl = 1'($urandom_range(0, 1));
            cpu_wr(a, d, nu, nl, 1'b1);
        end
        drain("random_drain");

        // Reset during STROBE
        cpu_wr(BASE + 24'h2, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 32 && bus.nvramWE !== 1'b0; i++) @(negedge clk);
        chk("reached_strobe", 32'(bus.nvramWE), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_we", 32'(bus.nvramWE), 1);
        chk("midrst_drive", 32'(bus.vramDrive), 0);
        chk("midrst_count", 32'(bus.fifoCount), 0);
        chk("midrst_ovf", 32'(bus.overflow), 0);
        chk("midrst_idle", 32'(dut.state_q), 32'(IDLE));
        exp_q.delete();
        #1;
        reset = 1'b0;
        wb = writes;
        drain("postrst_drain");
        chk("postrst_no_writes", writes - wb, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
